xy_route_compute_unit: RTL and testbench

// - Multi-VC route computation for one router of a rectangular DIM_X x DIM_Y mesh.
// - Successor to the single-channel combinational head-flit decoder:
//   - uniform port encoding;
//   - run-time XY/YX dimension order;
//   - out-of-mesh detection;
//   - one shared route unit, time-shared across VCs by a round-robin arbiter.
// - Sits between the input VC buffers and the switch allocator.

---
 rtl/xy_route_compute_unit_if.sv | 42 ++++
 rtl/xy_route_compute_unit.sv | 178 +++++++++++++++++
 tb/tb_xy_route_compute_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_route_compute_unit_if.sv
// Bundle between the input VC buffers (master) and the shared route unit (slave).
// Per-port decode counters exist only when RC_STATS_EN is defined.
interface xy_route_compute_unit_if #(
    parameter int VC            = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 3,
    parameter int STAT_WIDTH    = 16
);
    logic [VC-1:0]               decodeHeadFlit;
    logic [VC*DATA_WIDTH-1:0]    HeadFlit;
    logic                        route_yx;
    logic [VC*REQUEST_WIDTH-1:0] RequestMessage;
    logic [VC-1:0]               headFlitDecoded;
    logic [VC-1:0]               route_error;
`ifdef RC_STATS_EN
    logic [5*STAT_WIDTH-1:0]     port_count;
`endif

    modport master (
`ifdef RC_STATS_EN
        input  port_count,
`endif
        output decodeHeadFlit,
        output HeadFlit,
        output route_yx,
        input  RequestMessage,
        input  headFlitDecoded,
        input  route_error
    );

    modport slave (
`ifdef RC_STATS_EN
        output port_count,
`endif
        input  decodeHeadFlit,
        input  HeadFlit,
        input  route_yx,
        output RequestMessage,
        output headFlitDecoded,
        output route_error
    );
endinterface

// File: rtl/xy_route_compute_unit.sv
// Multi-VC XY/YX route computation for one node of a DIM_X x DIM_Y mesh.
// One route unit is time-shared across the VCs by a round-robin arbiter.
// Optional feature macro: RC_STATS_EN (per-output-port decode counters).
//
// Per-VC FSM:
//   state | meaning
//   IDLE  | no request outstanding
//   PEND  | request seen, waiting for the shared route unit
//   DONE  | result registered, headFlitDecoded high until the request drops
module xy_route_compute_unit #(
    parameter int DIM_X         = 4,
    parameter int DIM_Y         = 4,
    parameter int INDEX         = 1,
    parameter int DATA_WIDTH    = 8,
    parameter int VC            = 4,
    parameter int REQUEST_WIDTH = 3,
    parameter int STAT_WIDTH    = 16
) (
    input logic                    clk,
    input logic                    rst,
    xy_route_compute_unit_if.slave bus
);
    localparam int XB = $clog2(DIM_X);
    localparam int YB = $clog2(DIM_Y);
    localparam int PW = (VC > 1) ? $clog2(VC) : 1;

    localparam logic [XB-1:0] NODE_X = XB'(INDEX % DIM_X);
    localparam logic [YB-1:0] NODE_Y = YB'(INDEX / DIM_X);

    localparam logic [REQUEST_WIDTH-1:0] PORT_LOCAL = REQUEST_WIDTH'(0);
    localparam logic [REQUEST_WIDTH-1:0] PORT_EAST  = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] PORT_NORTH = REQUEST_WIDTH'(2);
    localparam logic [REQUEST_WIDTH-1:0] PORT_WEST  = REQUEST_WIDTH'(3);
    localparam logic [REQUEST_WIDTH-1:0] PORT_SOUTH = REQUEST_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } vcState_t;

    vcState_t stateQ [VC];
    vcState_t stateD [VC];

    logic [VC-1:0]               reqVec;
    logic [VC-1:0]               eligible;
    logic [VC-1:0]               decodedVec;
    logic [VC-1:0]               grantVec;
    logic [PW-1:0]               ptrQ;
    logic [PW-1:0]               grantIdx;
    logic                        anyGrant;
    logic [DATA_WIDTH-1:0]       selFlit;
    logic [XB-1:0]               destX;
    logic [YB-1:0]               destY;
    logic                        outOfMesh;
    logic [REQUEST_WIDTH-1:0]    routeCode;
    logic [VC*REQUEST_WIDTH-1:0] reqMsgQ;
    logic [VC-1:0]               errQ;
    logic                        unusedFlitBits;

    assign reqVec = bus.decodeHeadFlit;

    // Per-VC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC; v++) stateQ[v] <= IDLE;
        end else begin
            for (int v = 0; v < VC; v++) stateQ[v] <= stateD[v];
        end
    end

    // Per-VC next state; a dropped request wins over a grant in the same cycle.
    always_comb begin
        for (int v = 0; v < VC; v++) begin
            stateD[v] = stateQ[v];
            case (stateQ[v])
                IDLE:    if (reqVec[v]) stateD[v] = PEND;
                PEND: begin
                    if (!reqVec[v])       stateD[v] = IDLE;
                    else if (grantVec[v]) stateD[v] = DONE;
                end
                DONE:    if (!reqVec[v]) stateD[v] = IDLE;
                default: stateD[v] = IDLE;
            endcase
        end
    end

    // Per-VC FSM outputs: arbitration eligibility and result-valid flag.
    always_comb begin
        eligible   = '0;
        decodedVec = '0;
        for (int v = 0; v < VC; v++) begin
            eligible[v]   = (stateQ[v] == PEND) && reqVec[v];
            decodedVec[v] = (stateQ[v] == DONE);
        end
    end

    // Round-robin pick: first eligible VC at or after the pointer.
    always_comb begin
        anyGrant = 1'b0;
        grantIdx = '0;
        grantVec = '0;
        for (int i = 0; i < VC; i++) begin
            if (!anyGrant && eligible[(int'(ptrQ) + i) % VC]) begin
                anyGrant = 1'b1;
                grantIdx = PW'((int'(ptrQ) + i) % VC);
            end
        end
        for (int k = 0; k < VC; k++) grantVec[k] = anyGrant && (int'(grantIdx) == k);
    end

    // Pointer moves just past the VC that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ptrQ <= '0;
        else if (anyGrant) ptrQ <= PW'((int'(grantIdx) + 1) % VC);
    end

    // Shared route unit working on the granted VC's head flit.
    always_comb begin
        selFlit   = bus.HeadFlit[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
        destY     = selFlit[0 +: YB];
        destX     = selFlit[YB +: XB];
        outOfMesh = ({1'b0, destX} >= (XB+1)'(DIM_X)) || ({1'b0, destY} >= (YB+1)'(DIM_Y));
        routeCode = PORT_LOCAL;
        if (!outOfMesh) begin
            if (bus.route_yx) begin
                if (destY != NODE_Y)      routeCode = (destY > NODE_Y) ? PORT_NORTH : PORT_SOUTH;
                else if (destX != NODE_X) routeCode = (destX > NODE_X) ? PORT_EAST : PORT_WEST;
            end else begin
                if (destX != NODE_X)      routeCode = (destX > NODE_X) ? PORT_EAST : PORT_WEST;
                else if (destY != NODE_Y) routeCode = (destY > NODE_Y) ? PORT_NORTH : PORT_SOUTH;
            end
        end
    end

    // Payload bits above the destination fields are not needed for routing.
    assign unusedFlitBits = ^selFlit;

    // Capture the result into the granted VC's slot; other slots hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqMsgQ <= '0;
            errQ    <= '0;
        end else if (anyGrant) begin
            reqMsgQ[int'(grantIdx)*REQUEST_WIDTH +: REQUEST_WIDTH] <= routeCode;
            errQ[grantIdx]                                         <= outOfMesh;
        end
    end

    assign bus.RequestMessage  = reqMsgQ;
    assign bus.headFlitDecoded = decodedVec;
    assign bus.route_error     = errQ;

`ifdef RC_STATS_EN
    logic [STAT_WIDTH-1:0]   countQ [5];
    logic [5*STAT_WIDTH-1:0] portCount;

    // Saturating per-port grant counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 5; p++) countQ[p] <= '0;
        end else if (anyGrant) begin
            for (int p = 0; p < 5; p++) begin
                if (routeCode == REQUEST_WIDTH'(p) && countQ[p] != '1)
                    countQ[p] <= countQ[p] + STAT_WIDTH'(1);
            end
        end
    end

    // Flatten counters onto the port_count bus.
    always_comb begin
        portCount = '0;
        for (int p = 0; p < 5; p++) portCount[p*STAT_WIDTH +: STAT_WIDTH] = countQ[p];
    end

    assign bus.port_count = portCount;
`endif
endmodule

// File: tb/tb_xy_route_compute_unit.sv
// Bench for xy_route_compute_unit: a 4x4 node (INDEX 5, 4 VCs) driven from a
// vector table with a scoreboard, plus a 3x2 node (INDEX 0, 2 VCs) for
// out-of-mesh and narrow-counter cases.
module tb_xy_route_compute_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    xy_route_compute_unit_if #(.VC(4), .DATA_WIDTH(8), .REQUEST_WIDTH(3), .STAT_WIDTH(16)) bus ();
    xy_route_compute_unit_if #(.VC(2), .DATA_WIDTH(8), .REQUEST_WIDTH(3), .STAT_WIDTH(2))  bus2 ();

    xy_route_compute_unit #(
        .DIM_X(4), .DIM_Y(4), .INDEX(5), .DATA_WIDTH(8), .VC(4), .REQUEST_WIDTH(3), .STAT_WIDTH(16)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    xy_route_compute_unit #(
        .DIM_X(3), .DIM_Y(2), .INDEX(0), .DATA_WIDTH(8), .VC(2), .REQUEST_WIDTH(3), .STAT_WIDTH(2)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int passCnt  = 0;
    int totalCnt = 0;

    typedef struct {
        int vc;
        int code;
        bit err;
    } expT;
    expT expQ[$];

    typedef struct {
        int vc;
        int dx;
        int dy;
        bit yx;
        int code;
    } vecT;
    vecT tbl[12];

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] makeFlit(input int dx, input int dy);
        logic [7:0] f;
        f      = 8'($urandom_range(0, 15)) << 4;
        f[3:2] = dx[1:0];
        f[1:0] = dy[1:0];
        return f;
    endfunction

    function automatic logic [7:0] makeFlit2(input int dx, input int dy);
        logic [7:0] f;
        f      = 8'($urandom_range(0, 31)) << 3;
        f[2:1] = dx[1:0];
        f[0]   = dy[0];
        return f;
    endfunction

    // Scoreboard: compare the registered result when a VC's decoded flag rises.
    task automatic scoreRise(input int v);
        int idx;
        idx = -1;
        for (int i = 0; i < expQ.size(); i++) begin
            if (idx < 0 && expQ[i].vc == v) idx = i;
        end
        if (idx < 0) begin
            totalCnt++;
            $display("FAIL sb_unexpected_vc%0d: decoded rose with no expectation queued", v);
        end else begin
            check($sformatf("sb_code_vc%0d", v), int'(bus.RequestMessage[v*3 +: 3]), expQ[idx].code);
            check($sformatf("sb_err_vc%0d", v), int'(bus.route_error[v]), int'(expQ[idx].err));
            expQ.delete(idx);
        end
    endtask

    logic [3:0] prevDec;

    // Rising-edge detector on headFlitDecoded, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rst) prevDec = '0;
        else begin
            for (int v = 0; v < 4; v++) begin
                if (bus.headFlitDecoded[v] && !prevDec[v]) scoreRise(v);
            end
            prevDec = bus.headFlitDecoded;
        end
    end

    task automatic driveReq(input int v, input int dx, input int dy, input int code, input bit err);
        bus.HeadFlit[v*8 +: 8]  = makeFlit(dx, dy);
        bus.decodeHeadFlit[v]   = 1'b1;
        expQ.push_back('{v, code, err});
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic singleDecode(input int v, input int dx, input int dy, input bit yx, input int code);
        @(negedge clk);
        bus.route_yx = yx;
        driveReq(v, dx, dy, code, 1'b0);
        @(posedge clk); #1;
        check($sformatf("lat_pend_vc%0d", v), int'(bus.headFlitDecoded[v]), 0);
        @(posedge clk); #1;
        check($sformatf("lat_done_vc%0d", v), int'(bus.headFlitDecoded[v]), 1);
        @(negedge clk);
        @(negedge clk);
        bus.decodeHeadFlit[v] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("drop_vc%0d", v), int'(bus.headFlitDecoded[v]), 0);
        check($sformatf("hold_vc%0d", v), int'(bus.RequestMessage[v*3 +: 3]), code);
    endtask

    task automatic dut2Decode(input int v, input int dx, input int dy, input bit yx,
                              input int code, input bit err);
        @(negedge clk);
        bus2.route_yx              = yx;
        bus2.HeadFlit[v*8 +: 8]    = makeFlit2(dx, dy);
        bus2.decodeHeadFlit[v]     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check($sformatf("d2_done_vc%0d", v), int'(bus2.headFlitDecoded[v]), 1);
        check($sformatf("d2_code_vc%0d_x%0d_y%0d", v, dx, dy), int'(bus2.RequestMessage[v*3 +: 3]), code);
        check($sformatf("d2_err_vc%0d_x%0d_y%0d", v, dx, dy), int'(bus2.route_error[v]), int'(err));
        @(negedge clk);
        bus2.decodeHeadFlit[v] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // node (1,1): {vc, destX, destY, yx, expected code}
        tbl[0]  = '{0, 3, 1, 1'b0, 1};
        tbl[1]  = '{1, 2, 3, 1'b0, 1};
        tbl[2]  = '{2, 2, 3, 1'b1, 2};
        tbl[3]  = '{3, 1, 1, 1'b0, 0};
        tbl[4]  = '{0, 0, 1, 1'b0, 3};
        tbl[5]  = '{1, 1, 0, 1'b0, 4};
        tbl[6]  = '{2, 0, 3, 1'b1, 2};
        tbl[7]  = '{3, 0, 3, 1'b0, 3};
        tbl[8]  = '{0, 3, 0, 1'b1, 4};
        tbl[9]  = '{1, 1, 2, 1'b1, 2};
        tbl[10] = '{2, 1, 1, 1'b1, 0};
        tbl[11] = '{3, 2, 1, 1'b1, 1};

        rst                 = 1'b1;
        bus.decodeHeadFlit  = '0;
        bus.HeadFlit        = '0;
        bus.route_yx        = 1'b0;
        bus2.decodeHeadFlit = '0;
        bus2.HeadFlit       = '0;
        bus2.route_yx       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_decoded", int'(bus.headFlitDecoded), 0);
        check("reset_reqmsg", int'(bus.RequestMessage), 0);
        check("reset_err", int'(bus.route_error), 0);
        check("reset_d2_decoded", int'(bus2.headFlitDecoded), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            singleDecode(tbl[i].vc, tbl[i].dx, tbl[i].dy, tbl[i].yx, tbl[i].code);

        // route_yx flips while PEND: the value at the grant edge decides
        @(negedge clk);
        bus.route_yx = 1'b1;
        driveReq(1, 2, 3, 1, 1'b0);
        @(posedge clk); #1;
        bus.route_yx = 1'b0;
        @(posedge clk); #1;
        check("yx_late_decoded", int'(bus.headFlitDecoded[1]), 1);
        @(negedge clk);
        @(negedge clk);
        bus.decodeHeadFlit[1] = 1'b0;
        @(posedge clk); #1;

        // after serving VC2 the pointer sits at 3, so VC3 beats VC0
        singleDecode(2, 3, 1, 1'b0, 1);
        @(negedge clk);
        bus.route_yx = 1'b0;
        driveReq(0, 0, 1, 3, 1'b0);
        driveReq(3, 1, 0, 4, 1'b0);
        @(posedge clk); #1;
        check("rr_pend", int'(bus.headFlitDecoded), 4'b0000);
        @(posedge clk); #1;
        check("rr_first", int'(bus.headFlitDecoded), 4'b1000);
        @(posedge clk); #1;
        check("rr_second", int'(bus.headFlitDecoded), 4'b1001);
        @(negedge clk);
        bus.decodeHeadFlit = '0;
        @(posedge clk); #1;
        check("rr_drop", int'(bus.headFlitDecoded), 4'b0000);

        // all four at once right after reset: served 0,1,2,3
        doReset();
        @(negedge clk);
        bus.route_yx = 1'b0;
        driveReq(0, 3, 1, 1, 1'b0);
        driveReq(1, 0, 1, 3, 1'b0);
        driveReq(2, 1, 3, 2, 1'b0);
        driveReq(3, 1, 1, 0, 1'b0);
        @(posedge clk); #1;
        check("all4_pend", int'(bus.headFlitDecoded), 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("all4_grant%0d", k), int'(bus.headFlitDecoded), (1 << (k + 1)) - 1);
        end
        @(negedge clk);
        bus.decodeHeadFlit[1] = 1'b0;
        @(posedge clk); #1;
        check("all4_drop_vc1", int'(bus.headFlitDecoded), 4'b1101);
        @(negedge clk);
        bus.decodeHeadFlit = '0;
        @(posedge clk); #1;
        check("all4_drop_all", int'(bus.headFlitDecoded), 4'b0000);

        // abort while PEND: no result may appear
        @(negedge clk);
        bus.HeadFlit[2*8 +: 8] = makeFlit(3, 3);
        bus.decodeHeadFlit[2]  = 1'b1;
        @(posedge clk); #1;
        check("abort_pend", int'(bus.headFlitDecoded[2]), 0);
        @(negedge clk);
        bus.decodeHeadFlit[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort_quiet%0d", k), int'(bus.headFlitDecoded[2]), 0);
        end

        // reset while DONE, request held through it and restarted from IDLE
        @(negedge clk);
        bus.route_yx = 1'b0;
        driveReq(0, 3, 1, 1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstdone_decoded", int'(bus.headFlitDecoded[0]), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstdone_dec_clear", int'(bus.headFlitDecoded), 0);
        check("rstdone_msg_clear", int'(bus.RequestMessage), 0);
        check("rstdone_err_clear", int'(bus.route_error), 0);
        expQ.push_back('{0, 1, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstdone_restart_pend", int'(bus.headFlitDecoded[0]), 0);
        @(posedge clk); #1;
        check("rstdone_restart_done", int'(bus.headFlitDecoded[0]), 1);
        @(negedge clk);
        @(negedge clk);
        bus.decodeHeadFlit[0] = 1'b0;
        @(posedge clk); #1;

`ifdef RC_STATS_EN
        doReset();
        for (int k = 0; k < 3; k++) singleDecode(0, 3, 1, 1'b0, 1);
        for (int k = 0; k < 2; k++) singleDecode(1, 1, 1, 1'b0, 0);
        check("stats_east", int'(bus.port_count[16 +: 16]), 3);
        check("stats_local", int'(bus.port_count[0 +: 16]), 2);
        check("stats_north", int'(bus.port_count[32 +: 16]), 0);
`endif

        // 3x2 mesh, node (0,0)
        dut2Decode(0, 3, 0, 1'b0, 0, 1'b1);
        dut2Decode(1, 2, 1, 1'b0, 1, 1'b0);
        dut2Decode(0, 0, 1, 1'b0, 2, 1'b0);
        dut2Decode(1, 3, 1, 1'b1, 0, 1'b1);
        dut2Decode(0, 0, 0, 1'b1, 0, 1'b0);

`ifdef RC_STATS_EN
        doReset();
        for (int k = 0; k < 4; k++) dut2Decode(0, 0, 0, 1'b0, 0, 1'b0);
        dut2Decode(1, 1, 0, 1'b0, 1, 1'b0);
        check("d2_stats_sat", int'(bus2.port_count[0 +: 2]), 3);
        check("d2_stats_east", int'(bus2.port_count[2 +: 2]), 1);
`endif

        repeat (2) @(posedge clk);
        check("sb_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
